rk_fft_agu_param: RTL

//  Parametrised radix-2^LOG_R address generation unit for the memory-based NTT/FFT core.

---
 rtl/rk_fft_agu_param.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/rk_fft_agu_param.sv
// Address generation unit for the memory-based radix-2^LOG_R NTT/FFT core.
// Walks NUM_STG butterfly passes plus a final output pass (FFT mode), or a
// single digit-reversed transpose pass (RC mode). For every accepted beat it
// emits a conflict-free two-bank memory address, a twiddle ROM address, DTFAG
// digit indices and a stage tag. The stage tag is also delayed by STG_DLY cycles.
module rk_fft_agu_param #(
  parameter int LOG_R   = 4,
  parameter int NUM_STG = 3,
  parameter int DRAIN   = 48,
  parameter int STG_DLY = 48,
  localparam int NB     = LOG_R * NUM_STG,
  localparam int SW     = $clog2(NUM_STG + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mode,
  input  logic          en,
  output logic          busy,
  output logic          done,
  output logic          addr_vld,
  output logic [NB-2:0] ma,
  output logic          bank,
  output logic [NB-1:0] roma,
  output logic          final_stg,
  output logic [SW-1:0] stg,
  output logic [SW-1:0] fft_stage_dly,
  output logic [NB-1:0] dtfag_idx
);

  localparam int DCW = $clog2(DRAIN + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [NB-1:0]  P_MAX  = {NB{1'b1}};
  localparam logic [SW-1:0]  S_LAST = SW'(NUM_STG);
  localparam logic [DCW-1:0] D_LAST = DCW'(DRAIN - 1);

  logic [1:0]     state_r;
  logic [NB-1:0]  p_r;
  logic [SW-1:0]  s_r;
  logic [NB-1:0]  odo_r;
  logic           mode_r;
  logic [DCW-1:0] dcnt_r;
  logic [SW-1:0]  dly_r [STG_DLY];

  logic           accept_s;
  logic           last_s;
  logic [NB-1:0]  ba_s;
  logic [NB-1:0]  roma_s;

  // Rotate right by amt bit positions (amt < NB).
  function automatic logic [NB-1:0] rotr(input logic [NB-1:0] v, input int amt);
    logic [2*NB-1:0] d;
    d = {v, v} >> amt;
    return d[NB-1:0];
  endfunction

  // Reverse the order of the LOG_R-bit digits.
  function automatic logic [NB-1:0] digit_rev(input logic [NB-1:0] v);
    logic [NB-1:0] r;
    r = '0;
    for (int d = 0; d < NUM_STG; d++) begin
      r[d*LOG_R +: LOG_R] = v[(NUM_STG-1-d)*LOG_R +: LOG_R];
    end
    return r;
  endfunction

  // Base-2^LOG_R odometer step: lowest digit first, carry ripples upward.
  function automatic logic [NB-1:0] odo_inc(input logic [NB-1:0] v);
    logic [NB-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    for (int d = 0; d < NUM_STG; d++) begin
      if (carry) begin
        if (v[d*LOG_R +: LOG_R] == {LOG_R{1'b1}}) begin
          r[d*LOG_R +: LOG_R] = {LOG_R{1'b0}};
          carry = 1'b1;
        end else begin
          r[d*LOG_R +: LOG_R] = v[d*LOG_R +: LOG_R] + LOG_R'(1);
          carry = 1'b0;
        end
      end else begin
        carry = 1'b0;
      end
    end
    return r;
  endfunction

  // Beat acceptance, last-beat detection and address mapping for the current (p, s).
  always_comb begin
    accept_s = (state_r == ST_RUN) && en;
    last_s   = accept_s && (p_r == P_MAX) && (mode_r || (s_r == S_LAST));
    if (mode_r) begin
      ba_s = digit_rev(p_r);
    end else begin
      ba_s = rotr(p_r, (LOG_R * int'(s_r)) % NB);
    end
    // The final output pass and the transpose pass need no twiddles.
    if (mode_r || (s_r == S_LAST)) begin
      roma_s = '0;
    end else begin
      roma_s = ba_s << (LOG_R * int'(s_r));
    end
  end

  // Sequencer FSM, pass/point counters, odometer and registered address outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      p_r       <= '0;
      s_r       <= '0;
      odo_r     <= '0;
      mode_r    <= 1'b0;
      dcnt_r    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      addr_vld  <= 1'b0;
      ma        <= '0;
      bank      <= 1'b0;
      roma      <= '0;
      final_stg <= 1'b0;
      stg       <= '0;
      dtfag_idx <= '0;
    end else begin
      done     <= 1'b0;
      addr_vld <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            p_r       <= '0;
            s_r       <= '0;
            odo_r     <= '0;
            dtfag_idx <= '0;
            mode_r    <= mode;
            busy      <= 1'b1;
            state_r   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (accept_s) begin
            addr_vld  <= 1'b1;
            ma        <= ba_s[NB-1:1];
            bank      <= ^ba_s;
            roma      <= roma_s;
            final_stg <= ~mode_r && (s_r == S_LAST);
            stg       <= s_r;
            dtfag_idx <= odo_r;
            odo_r     <= odo_inc(odo_r);
            p_r       <= p_r + NB'(1);
            if (last_s) begin
              dcnt_r  <= '0;
              state_r <= ST_DRAIN;
            end else if (p_r == P_MAX) begin
              s_r <= s_r + SW'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (dcnt_r == D_LAST) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            dcnt_r <= dcnt_r + DCW'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Free-running delay line for the stage tag; shifts every cycle regardless of en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STG_DLY; i++) begin
        dly_r[i] <= '0;
      end
    end else begin
      dly_r[0] <= stg;
      for (int i = 1; i < STG_DLY; i++) begin
        dly_r[i] <= dly_r[i-1];
      end
    end
  end

  assign fft_stage_dly = dly_r[STG_DLY-1];

endmodule
